// File: rtl/csa_word_sequencer.sv
// Byte-serial adder/subtractor that time-shares one 8-bit conditional-sum adder across an NBYTES-byte word.
// Latency: operands accepted at edge T give out_valid from edge T+NBYTES; issue interval NBYTES+2 with out_ready high.
// Backpressure: in_ready drops for RUN and DONE; the result holds in DONE until out_ready. Subtract via CSA_SEQ_SUB_EN.

// 8-bit conditional-sum adder: every block computes both carry-in cases, merged in three select levels.
module conditional_sum_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c0,
    output logic [7:0] sum,
    output logic       c8
);

    logic [7:0] s0_0, s1_0, k0_0, k1_0;
    logic [7:0] s0_1, s1_1;
    logic [3:0] k0_1, k1_1;
    logic [7:0] s0_2, s1_2;
    logic [1:0] k0_2, k1_2;
    logic [7:0] s0_3, s1_3;
    logic       k0_3, k1_3;

    // Single-bit blocks, then merge pairs of blocks into 2-, 4- and 8-bit blocks.
    always_comb begin
        s0_0 = x ^ y;
        s1_0 = ~(x ^ y);
        k0_0 = x & y;
        k1_0 = x | y;

        s0_1 = s0_0;
        s1_1 = s1_0;
        k0_1 = '0;
        k1_1 = '0;
        for (int j = 0; j < 4; j++) begin
            s0_1[2*j+1] = k0_0[2*j] ? s1_0[2*j+1] : s0_0[2*j+1];
            s1_1[2*j+1] = k1_0[2*j] ? s1_0[2*j+1] : s0_0[2*j+1];
            k0_1[j]     = k0_0[2*j] ? k1_0[2*j+1] : k0_0[2*j+1];
            k1_1[j]     = k1_0[2*j] ? k1_0[2*j+1] : k0_0[2*j+1];
        end

        s0_2 = s0_1;
        s1_2 = s1_1;
        k0_2 = '0;
        k1_2 = '0;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 2; i++) begin
                s0_2[4*j+2+i] = k0_1[2*j] ? s1_1[4*j+2+i] : s0_1[4*j+2+i];
                s1_2[4*j+2+i] = k1_1[2*j] ? s1_1[4*j+2+i] : s0_1[4*j+2+i];
            end
            k0_2[j] = k0_1[2*j] ? k1_1[2*j+1] : k0_1[2*j+1];
            k1_2[j] = k1_1[2*j] ? k1_1[2*j+1] : k0_1[2*j+1];
        end

        s0_3 = s0_2;
        s1_3 = s1_2;
        for (int i = 0; i < 4; i++) begin
            s0_3[4+i] = k0_2[0] ? s1_2[4+i] : s0_2[4+i];
            s1_3[4+i] = k1_2[0] ? s1_2[4+i] : s0_2[4+i];
        end
        k0_3 = k0_2[0] ? k1_2[1] : k0_2[1];
        k1_3 = k1_2[0] ? k1_2[1] : k0_2[1];

        sum = c0 ? s1_3 : s0_3;
        c8  = c0 ? k1_3 : k0_3;
    end

endmodule

module csa_word_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
`ifdef CSA_SEQ_SUB_EN
    input  logic                sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                busy
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic [CW-1:0]   byte_cnt;
    logic [7:0]      add_x;
    logic [7:0]      add_y;
    logic [7:0]      add_sum;
    logic            add_c8;
`ifdef CSA_SEQ_SUB_EN
    logic            sub_q;
`endif

    // Steer byte k of the captured operands into the shared adder; B is inverted when subtracting.
    always_comb begin
        add_x = a_q[{byte_cnt, 3'b000} +: 8];
`ifdef CSA_SEQ_SUB_EN
        add_y = b_q[{byte_cnt, 3'b000} +: 8] ^ {8{sub_q}};
`else
        add_y = b_q[{byte_cnt, 3'b000} +: 8];
`endif
    end

    conditional_sum_adder u_adder (
        .x   (add_x),
        .y   (add_y),
        .c0  (carry_q),
        .sum (add_sum),
        .c8  (add_c8)
    );

    // Sequencer FSM with operand capture, byte-wise result assembly and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            byte_cnt  <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef CSA_SEQ_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
`ifdef CSA_SEQ_SUB_EN
                        sub_q    <= sub;
                        // Two's-complement subtract: inverted B plus an initial carry of one.
                        carry_q  <= sub ? 1'b1 : cin;
`else
                        carry_q  <= cin;
`endif
                        byte_cnt <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum[{byte_cnt, 3'b000} +: 8] <= add_sum;
                    carry_q  <= add_c8;
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == CW'(NBYTES - 1)) begin
                        cout      <= add_c8;
                        byte_cnt  <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    byte_cnt  <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_word_sequencer.sv
// Directed bench for csa_word_sequencer at NBYTES=4: add, carry ripple, backpressure, reset mid-run, back-to-back.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// The subtract case is exercised only when CSA_SEQ_SUB_EN is defined.
module tb_csa_word_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
`ifdef CSA_SEQ_SUB_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    csa_word_sequencer #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CSA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one operand set from IDLE, scramble the inputs afterwards, and check latency and result.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_val, input logic tc,
                         input logic [31:0] es, input logic ec, input string tag);
        int n;
        in_valid = 1'b1;
        a = ta;
        b = tb_val;
        cin = tc;
        tick();
        in_valid = 1'b0;
        a = ~ta;
        b = 32'hDEAD_BEEF;
        cin = ~tc;
        check({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
    endtask

    task automatic release_result(input string tag, input logic [31:0] es);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
        check({tag, "_sum_held"}, 64'(sum), 64'(es));
    endtask

    logic [31:0] ops_a [3];
    logic [31:0] ops_b [3];
    logic [31:0] exp_s [3];
    logic        exp_c [3];
    int          acc   [3];

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef CSA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        rst = 1'b0;

        // Basic add.
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, "basic");
        check("basic_busy_done", 64'(busy), 64'd1);
        release_result("basic", 32'h2345_6789);
        check("basic_busy_idle", 64'(busy), 64'd0);

        // Carry ripples through every byte.
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, "ripple");
        release_result("ripple", 32'h0000_0000);

        // Backpressure: result held for 10 cycles, stray in_valid ignored.
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, "bp");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                a = 32'h7777_7777;
                b = 32'h1234_0000;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_sum", 64'(sum), 64'h0000_0100);
        end
        in_valid = 1'b0;
        release_result("bp", 32'h0000_0100);
        // Stray out_ready in IDLE must not disturb anything.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_ready_valid", 64'(out_valid), 64'd0);
        check("idle_out_ready_in_ready", 64'(in_ready), 64'd1);

        // Reset during the second RUN cycle.
        in_valid = 1'b1;
        a = 32'hAAAA_AAAA;
        b = 32'h5555_5555;
        cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        check("rstrun_busy_before", 64'(busy), 64'd1);
        check("rstrun_sum_partial", 64'(sum), 64'h0000_01FF);
        rst = 1'b1;
        #1;
        check("rstrun_out_valid", 64'(out_valid), 64'd0);
        check("rstrun_sum", 64'(sum), 64'd0);
        check("rstrun_in_ready", 64'(in_ready), 64'd1);
        check("rstrun_busy", 64'(busy), 64'd0);
        check("rstrun_cout", 64'(cout), 64'd0);
        #1;
        rst = 1'b0;
        do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, "post_rst");
        release_result("post_rst", 32'h0000_0002);

        // Back-to-back with out_ready tied high.
        ops_a[0] = 32'h0000_0010; ops_b[0] = 32'h0000_0020; exp_s[0] = 32'h0000_0030; exp_c[0] = 1'b0;
        ops_a[1] = 32'h8000_0000; ops_b[1] = 32'h8000_0000; exp_s[1] = 32'h0000_0000; exp_c[1] = 1'b1;
        ops_a[2] = 32'h0000_FFFF; ops_b[2] = 32'h0000_0001; exp_s[2] = 32'h0001_0000; exp_c[2] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            check("b2b_wait_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            a = ops_a[i];
            b = ops_b[i];
            cin = 1'b0;
            tick();
            acc[i] = cyc;
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            check("b2b_latency", 64'(n), 64'd4);
            check("b2b_sum", 64'(sum), 64'(exp_s[i]));
            check("b2b_cout", 64'(cout), 64'(exp_c[i]));
            if (i > 0) check("b2b_interval", 64'(acc[i] - acc[i-1]), 64'd6);
        end
        tick();
        out_ready = 1'b0;
        check("b2b_idle", 64'(in_ready), 64'd1);

`ifdef CSA_SEQ_SUB_EN
        // Subtraction: cin is ignored, cout=1 means no borrow.
        sub = 1'b1;
        do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, "sub_borrow");
        release_result("sub_borrow", 32'hFFFF_FFFE);
        do_op(32'h0000_0007, 32'h0000_0005, 1'b0, 32'h0000_0002, 1'b1, "sub_noborrow");
        release_result("sub_noborrow", 32'h0000_0002);
        sub = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
